// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S memory geometry, key length, KSA state encoding
// and the key byte selector used by the key-scheduling stage.
package rc4_pkg;

  localparam int S_DEPTH   = 256;
  localparam int KEY_BYTES = 3;

  localparam logic [7:0] I_LAST = 8'(S_DEPTH - 1);

  typedef enum logic [2:0] {
    KSA_IDLE = 3'd0,
    KSA_INIT = 3'd1,
    KSA_RD_I = 3'd2,
    KSA_LD_I = 3'd3,
    KSA_RD_J = 3'd4,
    KSA_LD_J = 3'd5,
    KSA_WR_I = 3'd6,
    KSA_WR_J = 3'd7
  } ksa_state_e;

  // Key byte 0 sits in the top byte of the key word.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [7:0] idx);
    logic [7:0] sel;
    sel = idx % 8'(KEY_BYTES);
    case (sel)
      8'd0:    key_byte = key[23:16];
      8'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes S in place under a 24-bit key.
// Define KSA_INIT_EN to fill S with the identity permutation before scheduling.
module ksa
  import rc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  ksa_state_e  state_r, state_s;
  logic [7:0]  i_r, i_s;
  logic [7:0]  j_r, j_s;
  logic [7:0]  si_r, si_s;
  logic [7:0]  sj_r, sj_s;
  logic [23:0] key_r, key_s;

  logic        rdy_s;
  logic [7:0]  addr_s;
  logic [7:0]  wrdata_s;
  logic        wren_s;

  // Next-state and datapath update for the scheduling FSM
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    si_s    = si_r;
    sj_s    = sj_r;
    key_s   = key_r;
    case (state_r)
      KSA_IDLE: begin
        if (en) begin
          key_s = key;
          i_s   = 8'd0;
          j_s   = 8'd0;
`ifdef KSA_INIT_EN
          state_s = KSA_INIT;
`else
          state_s = KSA_RD_I;
`endif
        end else begin
          state_s = KSA_IDLE;
        end
      end
`ifdef KSA_INIT_EN
      KSA_INIT: begin
        if (i_r == I_LAST) begin
          i_s     = 8'd0;
          state_s = KSA_RD_I;
        end else begin
          i_s     = i_r + 8'd1;
          state_s = KSA_INIT;
        end
      end
`endif
      KSA_RD_I: state_s = KSA_LD_I;
      KSA_LD_I: begin
        si_s    = s_rddata;
        j_s     = j_r + s_rddata + key_byte(key_r, i_r);
        state_s = KSA_RD_J;
      end
      KSA_RD_J: state_s = KSA_LD_J;
      KSA_LD_J: begin
        sj_s    = s_rddata;
        state_s = KSA_WR_I;
      end
      KSA_WR_I: state_s = KSA_WR_J;
      KSA_WR_J: begin
        // i wraps to 0 on the final iteration, leaving it cleared for the next run
        i_s = i_r + 8'd1;
        if (i_r == I_LAST) begin
          state_s = KSA_IDLE;
        end else begin
          state_s = KSA_RD_I;
        end
      end
      default: state_s = KSA_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the port registers line up with it
  always_comb begin
    rdy_s    = 1'b0;
    addr_s   = 8'd0;
    wrdata_s = 8'd0;
    wren_s   = 1'b0;
    case (state_s)
      KSA_IDLE: rdy_s = 1'b1;
`ifdef KSA_INIT_EN
      KSA_INIT: begin
        wren_s   = 1'b1;
        addr_s   = i_s;
        wrdata_s = i_s;
      end
`endif
      KSA_RD_I: addr_s = i_s;
      KSA_RD_J: addr_s = j_s;
      KSA_WR_I: begin
        wren_s   = 1'b1;
        addr_s   = i_s;
        wrdata_s = sj_s;
      end
      KSA_WR_J: begin
        wren_s   = 1'b1;
        addr_s   = j_s;
        wrdata_s = si_s;
      end
      default: begin
        rdy_s    = 1'b0;
        addr_s   = 8'd0;
        wrdata_s = 8'd0;
        wren_s   = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= KSA_IDLE;
      i_r      <= 8'd0;
      j_r      <= 8'd0;
      si_r     <= 8'd0;
      sj_r     <= 8'd0;
      key_r    <= 24'd0;
      rdy      <= 1'b1;
      s_addr   <= 8'd0;
      s_wrdata <= 8'd0;
      s_wren   <= 1'b0;
    end else begin
      state_r  <= state_s;
      i_r      <= i_s;
      j_r      <= j_s;
      si_r     <= si_s;
      sj_r     <= sj_s;
      key_r    <= key_s;
      rdy      <= rdy_s;
      s_addr   <= addr_s;
      s_wrdata <= wrdata_s;
      s_wren   <= wren_s;
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: behavioural S memory, write log and a software KSA reference.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] key = 24'd0;
  logic        rdy;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;

  logic [7:0]  mem [256];
  logic [7:0]  exp_s [256];
  logic [1:0]  load_req = 2'd0;
  logic [7:0]  wa_q[$];
  logic [7:0]  wd_q[$];
  logic [7:0]  ref_a[$];
  logic [7:0]  ref_d[$];

  int n_checks = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  ksa dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .key      (key),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren)
  );

  // S memory: one-cycle read latency, bulk preload on request
  always @(posedge clk) begin
    if (load_req == 2'd1) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (load_req == 2'd2) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'hFF;
    end else if (s_wren) begin
      mem[s_addr] <= s_wrdata;
    end
    s_rddata <= mem[s_addr];
  end

  // Write log, cleared by every preload
  always @(posedge clk) begin
    if (load_req != 2'd0) begin
      wa_q.delete();
      wd_q.delete();
    end else if (rst_n && s_wren) begin
      wa_q.push_back(s_addr);
      wd_q.push_back(s_wrdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input logic [1:0] mode);
    @(negedge clk);
    load_req = mode;
    @(posedge clk);
    @(negedge clk);
    load_req = 2'd0;
  endtask

  task automatic exp_identity();
    for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
  endtask

  task automatic sw_ksa(input logic [23:0] k);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      j = j + exp_s[i] + kb;
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_s[i]) bad++;
    check(tag, bad, 0);
  endtask

  // Called at a negedge; returns at the negedge of the cycle where rdy is back (cycle index)
  task automatic run_ksa(input logic [23:0] k, input bit disturb, input bit hold,
                         input int abort_at, output int cycles);
    int n;
    key = k;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("accept_rdy_low", rdy, 1'b0);
    en = hold;
    n = 1;
    while (!rdy && n < 3000 && n != abort_at) begin
      if (disturb) begin
        en  = (n % 37 == 0);
        key = key ^ 24'h5A5A5A;
      end
      @(negedge clk);
      n++;
    end
    en = hold;
    if (abort_at == 0) check("run_in_budget", (n < 3000), 1'b1);
    cycles = n;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rdy", rdy, 1'b1);
    check("reset_wren", s_wren, 1'b0);
    check("reset_addr", s_addr, 8'd0);
    check("reset_wrdata", s_wrdata, 8'd0);
    repeat (5) @(negedge clk);
    check("idle_no_writes", wa_q.size(), 0);

`ifdef KSA_INIT_EN
    begin
      int bad;
      load_mem(2'd2);
      run_ksa(24'h000000, 1'b0, 1'b0, 0, cyc);
      check("init_rdy_cycle", cyc, 1793);
      check("init_write_count", wa_q.size(), 768);
      bad = 0;
      for (int i = 0; i < 256; i++) if (wa_q[i] !== 8'(i) || wd_q[i] !== 8'(i)) bad++;
      check("init_fill", bad, 0);
      check("it0_wr_i_addr", wa_q[256], 8'd0);
      check("it0_wr_j_data", wd_q[257], 8'd0);
      check("it1_wr_i_addr", wa_q[258], 8'd1);
      check("it1_wr_j_data", wd_q[259], 8'd1);
      check("it2_wr_i_addr", wa_q[260], 8'd2);
      check("it2_wr_i_data", wd_q[260], 8'd3);
      check("it2_wr_j_addr", wa_q[261], 8'd3);
      check("it2_wr_j_data", wd_q[261], 8'd2);
      exp_identity();
      sw_ksa(24'h000000);
      cmp_mem("init_final_s");
    end
`else
    begin
      int bad;
      // Undisturbed reference run
      load_mem(2'd1);
      run_ksa(24'h00033C, 1'b0, 1'b0, 0, cyc);
      check("rdy_cycle", cyc, 1537);
      check("write_count", wa_q.size(), 512);
      check("it0_addr", wa_q[0], 8'd0);
      check("it1_wr_i", {wa_q[2], wd_q[2]}, 16'h0104);
      check("it1_wr_j", {wa_q[3], wd_q[3]}, 16'h0401);
      check("it2_wr_i", {wa_q[4], wd_q[4]}, 16'h0242);
      check("it2_wr_j", {wa_q[5], wd_q[5]}, 16'h4202);
      check("it3_wr_i", {wa_q[6], wd_q[6]}, 16'h0345);
      exp_identity();
      sw_ksa(24'h00033C);
      cmp_mem("final_s_key033c");
      ref_a = wa_q;
      ref_d = wd_q;

      // en pulses and key changes while busy must not disturb the run
      load_mem(2'd1);
      run_ksa(24'h00033C, 1'b1, 1'b0, 0, cyc);
      check("disturb_rdy_cycle", cyc, 1537);
      check("disturb_write_count", wa_q.size(), ref_a.size());
      bad = 0;
      for (int i = 0; i < ref_a.size(); i++)
        if (wa_q[i] !== ref_a[i] || wd_q[i] !== ref_d[i]) bad++;
      check("disturb_write_seq", bad, 0);
      cmp_mem("disturb_final_s");

      // Reset during iteration 100, then re-run from identity
      load_mem(2'd1);
      run_ksa(24'hA55A01, 1'b0, 1'b0, 601, cyc);
      check("abort_busy", rdy, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midreset_rdy", rdy, 1'b1);
      check("midreset_wren", s_wren, 1'b0);
      check("midreset_addr", s_addr, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_idle", rdy, 1'b1);
      load_mem(2'd1);
      run_ksa(24'hA55A01, 1'b0, 1'b0, 0, cyc);
      check("rerun_rdy_cycle", cyc, 1537);
      exp_identity();
      sw_ksa(24'hA55A01);
      cmp_mem("rerun_final_s");

      // Back-to-back runs with en held high
      load_mem(2'd1);
      run_ksa(24'hFF0080, 1'b0, 1'b1, 0, cyc);
      check("b2b_first_cycle", cyc, 1537);
      run_ksa(24'hFF0080, 1'b0, 1'b0, 0, cyc);
      check("b2b_second_cycle", cyc, 1537);
      exp_identity();
      sw_ksa(24'hFF0080);
      sw_ksa(24'hFF0080);
      cmp_mem("b2b_final_s");
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
